vdp_output_fader: RTL and testbench
===================================

Name: vdp_output_fader

Overview:
- Final VDP pixel stage, directly downstream of the layer blender.
- Takes the blender's 12-bit RGB444 output and the raw video timing (hsync/vsync/de), and delays the timing to line up with the blender's pipeline.
- Applies a master-brightness scale controlled by a frame-paced fade-in/fade-out state machine, then registers the final RGB and sync signals for the video encoder.

Parameters:
- SYNC_DELAY, 4: cycles that color_in lags the timing inputs (blender pipeline depth).
- FADE_STEP_FRAMES, 2: vsync rising edges per brightness step (valid range 1..255).
- RESET_LEVEL, 16: brightness level after reset (valid range 0..16).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous reset, active-low.
- color_in  in  12  blender output, RGB444, {r[11:8], g[7:4], b[3:0]}.
- hsync_in  in  1  raw hsync, SYNC_DELAY cycles ahead of color_in.
- vsync_in  in  1  raw vsync, active-high, same timing as hsync_in.
- de_in  in  1  raw display enable, same timing as hsync_in.
- fade_start  in  1  1-cycle strobe that starts a fade.
- fade_dir  in  1  sampled with fade_start: 1 = fade in (toward 16), 0 = fade out (toward 0).
- level  out  5  current brightness level, 0..16.
- fade_busy  out  1  high while FADE_IN or FADE_OUT.
- fade_done  out  1  1-cycle pulse when a fade completes.
- r_out, g_out, b_out  out  4 each  final color.
- hsync_out, vsync_out, de_out  out  1 each  timing aligned with RGB.

Behaviour:
- Reset (async assert, sync release):
  - all RGB and sync outputs 0;
  - level = RESET_LEVEL;
  - state IDLE;
  - fade_busy = 0, fade_done = 0;
  - frame counter 0;
  - delay lines cleared to 0.
- Alignment:
  - hsync/vsync/de pass through a SYNC_DELAY-deep shift register, giving aligned_* timed with color_in.
  - Then one more register stage, so outputs appear SYNC_DELAY+1 cycles after the timing inputs.
- Color scaling (1 register stage, so color_in → RGB outputs latency is 1 cycle):
  - per channel: product = c × level, an 8-bit result (max 15 × 16 = 240); out = product[7:4];
  - level 16 passes color through unchanged; level 0 gives black;
  - when aligned_de = 0, RGB outputs are forced to 0.
- Level update timing:
  - vsync edge = rising edge of vsync_in, detected with a registered copy of vsync_in;
  - level changes only on the cycle after a vsync edge, so it never changes mid-frame.
- FSM states: IDLE, FADE_IN, FADE_OUT.
  - IDLE + fade_start: go to FADE_IN if fade_dir = 1, else FADE_OUT; clear frame counter.
  - FADE_IN/FADE_OUT on a vsync edge: frame counter increments. When it reaches FADE_STEP_FRAMES:
    - counter clears;
    - level ±1;
    - if the new level is 16 (in) or 0 (out): go to IDLE and pulse fade_done for 1 cycle.
  - fade_start while busy: restart in the new direction from the current level and clear the counter. Reversal is legal; there is no done pulse for the aborted fade.
  - fade_start when level is already at the target (16 for in, 0 for out):
    - go to or stay in IDLE;
    - pulse fade_done on the next cycle;
    - level unchanged.
  - fade_start and a vsync edge in the same cycle: fade_start wins; that edge is not counted.
- fade_busy = (state != IDLE), registered.
- Reset asserted mid-fade: immediate return to the reset values; no fade_done.

Optional Feature:
- Macro: VDP_OUTPUT_DITHER_EN.
- When defined, a 2×2 ordered dither replaces truncation:
  - x parity toggles on each aligned_de cycle and clears when aligned_de = 0;
  - y parity toggles on each aligned_de falling edge and clears on an aligned_vsync rising edge;
  - threshold t by (y,x): (0,0) = 0, (0,1) = 8, (1,0) = 12, (1,1) = 4;
  - out = min(15, (product + t) >> 4).
- Level 16 is still exact, because the fraction bits are 0 and t < 16.
- When undefined: plain truncation, and no x/y counters are synthesized.

Test Plan:
- Reset, then color_in = 12'hF84, de_in = 1 held, level 16 → r/g/b_out = F/8/4 one cycle later; de_out rises SYNC_DELAY+1 (5) cycles after de_in.
- fade_start with fade_dir = 0 from level 16, FADE_STEP_FRAMES = 2, 32 vsync pulses → level reaches 0 after the 32nd edge, fade_done pulses once, fade_busy falls.
  - At level 8, color 12'hF84 gives 7/4/2 (undithered).
- Fade out to level 10, then fade_start with fade_dir = 1 → direction reverses, no done pulse, level increments every 2 frames from 10 up to 16.
- fade_start with fade_dir = 1 at level 16 → fade_done next cycle, fade_busy stays 0, level stays 16.
- fade_start coincident with a vsync edge → that edge is not counted; the first step happens 2 further edges later.
- de_in = 0 with color_in = 12'hFFF → RGB outputs 0. Assert reset_n = 0 mid-fade → all outputs 0 immediately and level = RESET_LEVEL.

Source files
------------

// File: rtl/vdp_output_fader_if.sv
// Pixel/timing/fade bundle for the final VDP output fader.
// slave = fader side, master = upstream blender/controller side.
interface vdp_output_fader_if;
    logic [11:0] color_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic        fade_start;
    logic        fade_dir;
    logic [4:0]  level;
    logic        fade_busy;
    logic        fade_done;
    logic [3:0]  r_out;
    logic [3:0]  g_out;
    logic [3:0]  b_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;

    modport slave (
        input  color_in, hsync_in, vsync_in, de_in,
        input  fade_start, fade_dir,
        output level, fade_busy, fade_done,
        output r_out, g_out, b_out,
        output hsync_out, vsync_out, de_out
    );

    modport master (
        output color_in, hsync_in, vsync_in, de_in,
        output fade_start, fade_dir,
        input  level, fade_busy, fade_done,
        input  r_out, g_out, b_out,
        input  hsync_out, vsync_out, de_out
    );
endinterface

// File: rtl/vdp_output_fader.sv
// Final VDP stage: sync alignment, master brightness, frame-paced fader.
// Define VDP_OUTPUT_DITHER_EN for 2x2 ordered dither instead of truncation.
module vdp_output_fader #(
    parameter int SYNC_DELAY       = 4,
    parameter int FADE_STEP_FRAMES = 2,
    parameter int RESET_LEVEL      = 16
) (
    input logic          clk,
    input logic          reset_n,
    vdp_output_fader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} state_t;

    localparam logic [7:0] STEP = 8'(FADE_STEP_FRAMES);
    localparam logic [4:0] LVL0 = 5'(RESET_LEVEL);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [4:0]  lvl, lvl_n;
    logic        done_n;
    logic        vs_prev;
    logic        vs_edge;
    logic [2:0]  tim_sr [SYNC_DELAY];
    logic        a_hs, a_vs, a_de;

    assign vs_edge = bus.vsync_in & ~vs_prev;
    assign a_hs    = tim_sr[SYNC_DELAY-1][2];
    assign a_vs    = tim_sr[SYNC_DELAY-1][1];
    assign a_de    = tim_sr[SYNC_DELAY-1][0];
    assign bus.level = lvl;

    // Timing shift register aligning raw sync with the blender pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_DELAY; i++) tim_sr[i] <= '0;
            vs_prev <= 1'b0;
        end else begin
            tim_sr[0] <= {bus.hsync_in, bus.vsync_in, bus.de_in};
            for (int i = 1; i < SYNC_DELAY; i++) tim_sr[i] <= tim_sr[i-1];
            vs_prev <= bus.vsync_in;
        end
    end

    // Fader state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lvl           <= LVL0;
            bus.fade_done <= 1'b0;
            bus.fade_busy <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            lvl           <= lvl_n;
            bus.fade_done <= done_n;
            bus.fade_busy <= (state_n != IDLE);
        end
    end

    // Next state: a start strobe always wins over a same-cycle vsync edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lvl_n   = lvl;
        done_n  = 1'b0;
        if (bus.fade_start) begin
            cnt_n = '0;
            if ((bus.fade_dir && lvl == 5'd16) ||
                (!bus.fade_dir && lvl == 5'd0)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                state_n = bus.fade_dir ? FADE_IN : FADE_OUT;
            end
        end else if (vs_edge && state != IDLE) begin
            if (cnt + 8'd1 >= STEP) begin
                cnt_n = '0;
                lvl_n = (state == FADE_IN) ? lvl + 5'd1 : lvl - 5'd1;
                if ((state == FADE_IN && lvl_n == 5'd16) ||
                    (state == FADE_OUT && lvl_n == 5'd0)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
    end

    logic [7:0] pr_r, pr_g, pr_b;
    logic [3:0] o_r, o_g, o_b;

    assign pr_r = 8'(bus.color_in[11:8]) * 8'(lvl);
    assign pr_g = 8'(bus.color_in[7:4])  * 8'(lvl);
    assign pr_b = 8'(bus.color_in[3:0])  * 8'(lvl);

`ifdef VDP_OUTPUT_DITHER_EN
    logic       xp, yp, ad_prev, av_prev;
    logic [3:0] thr;

    // Screen-position parity for the 2x2 dither matrix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xp      <= 1'b0;
            yp      <= 1'b0;
            ad_prev <= 1'b0;
            av_prev <= 1'b0;
        end else begin
            xp      <= a_de ? ~xp : 1'b0;
            ad_prev <= a_de;
            av_prev <= a_vs;
            if (a_vs && !av_prev) yp <= 1'b0;
            else if (ad_prev && !a_de) yp <= ~yp;
        end
    end

    // Threshold lookup by (y,x).
    always_comb begin
        thr = 4'd0;
        unique case ({yp, xp})
            2'b00: thr = 4'd0;
            2'b01: thr = 4'd8;
            2'b10: thr = 4'd12;
            2'b11: thr = 4'd4;
        endcase
    end

    function automatic logic [3:0] dith(input logic [7:0] p,
                                        input logic [3:0] t);
        logic [8:0] s;
        s = {1'b0, p} + 9'(t);
        return (s[8:4] > 5'd15) ? 4'd15 : s[7:4];
    endfunction

    assign o_r = dith(pr_r, thr);
    assign o_g = dith(pr_g, thr);
    assign o_b = dith(pr_b, thr);
`else
    assign o_r = pr_r[7:4];
    assign o_g = pr_g[7:4];
    assign o_b = pr_b[7:4];
`endif

    // Output register: scaled colour blanked outside active video.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.r_out     <= '0;
            bus.g_out     <= '0;
            bus.b_out     <= '0;
            bus.hsync_out <= 1'b0;
            bus.vsync_out <= 1'b0;
            bus.de_out    <= 1'b0;
        end else begin
            bus.r_out     <= a_de ? o_r : 4'd0;
            bus.g_out     <= a_de ? o_g : 4'd0;
            bus.b_out     <= a_de ? o_b : 4'd0;
            bus.hsync_out <= a_hs;
            bus.vsync_out <= a_vs;
            bus.de_out    <= a_de;
        end
    end
endmodule

// File: tb/tb_vdp_output_fader.sv
// Directed bench for vdp_output_fader (default, undithered build).
// Inputs change 1ns after posedge; outputs are sampled at the same point.
module tb_vdp_output_fader;
    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;
    int   done_cnt;
    int   d0;
    int   exp_lvl;

    vdp_output_fader_if bus ();

    vdp_output_fader #(
        .SYNC_DELAY(4),
        .FADE_STEP_FRAMES(2),
        .RESET_LEVEL(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.fade_done) done_cnt++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vpulse();
        bus.vsync_in = 1'b1;
        tick();
        bus.vsync_in = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic start(input logic dir);
        bus.fade_start = 1'b1;
        bus.fade_dir   = dir;
        tick();
        bus.fade_start = 1'b0;
    endtask

    task automatic chk_rgb(input string tag, input logic [11:0] exp);
        chk(tag, {4'd0, bus.r_out, bus.g_out, bus.b_out}, {4'd0, exp});
    endtask

    initial begin
        n_chk = 0; n_err = 0; done_cnt = 0;
        bus.color_in = '0; bus.hsync_in = 0; bus.vsync_in = 0;
        bus.de_in = 0; bus.fade_start = 0; bus.fade_dir = 0;
        reset_n = 1'b0;
        #12;
        chk("rst_rgb", {4'd0, bus.r_out, bus.g_out, bus.b_out}, 16'h0);
        chk("rst_de", 16'(bus.de_out), 16'h0);
        chk("rst_lvl", 16'(bus.level), 16'd16);
        chk("rst_busy", 16'(bus.fade_busy), 16'h0);
        chk("rst_done", 16'(bus.fade_done), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Latency: de 5 cycles, colour 1 cycle behind aligned de.
        bus.color_in = 12'hF84;
        bus.de_in    = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        chk("de_lat4", 16'(bus.de_out), 16'h0);
        tick();
        chk("de_lat5", 16'(bus.de_out), 16'h1);
        chk_rgb("rgb_l16", 12'hF84);
        bus.color_in = 12'h123;
        tick();
        chk_rgb("rgb_1cyc", 12'h123);
        bus.color_in = 12'hF84;
        tick();

        // Full fade out: 32 edges, one step per 2 edges.
        d0 = done_cnt;
        start(1'b0);
        chk("fo_busy", 16'(bus.fade_busy), 16'h1);
        for (int i = 1; i <= 32; i++) begin
            vpulse();
            exp_lvl = 16 - i / 2;
            chk("fo_lvl", 16'(bus.level), 16'(exp_lvl));
            if (i == 16) chk_rgb("rgb_l8", 12'h742);
        end
        chk("fo_done", 16'(done_cnt - d0), 16'd1);
        chk("fo_idle", 16'(bus.fade_busy), 16'h0);
        chk_rgb("rgb_l0", 12'h000);

        // Fade out already at 0: immediate done, no busy.
        d0 = done_cnt;
        start(1'b0);
        chk("at0_done", 16'(bus.fade_done), 16'h1);
        chk("at0_busy", 16'(bus.fade_busy), 16'h0);
        tick();
        chk("at0_cnt", 16'(done_cnt - d0), 16'd1);
        chk("at0_lvl", 16'(bus.level), 16'd0);

        // Back to 16 via reset; fade in at 16 is immediate done.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        chk("rst2_lvl", 16'(bus.level), 16'd16);
        d0 = done_cnt;
        start(1'b1);
        chk("at16_done", 16'(bus.fade_done), 16'h1);
        chk("at16_busy", 16'(bus.fade_busy), 16'h0);
        tick();
        chk("at16_lvl", 16'(bus.level), 16'd16);
        chk("at16_cnt", 16'(done_cnt - d0), 16'd1);

        // Fade out to 10, reverse, climb back to 16.
        d0 = done_cnt;
        start(1'b0);
        for (int i = 1; i <= 12; i++) vpulse();
        chk("rev_l10", 16'(bus.level), 16'd10);
        start(1'b1);
        chk("rev_busy", 16'(bus.fade_busy), 16'h1);
        chk("rev_lvl", 16'(bus.level), 16'd10);
        for (int i = 1; i <= 12; i++) begin
            vpulse();
            exp_lvl = 10 + i / 2;
            chk("rev_up", 16'(bus.level), 16'(exp_lvl));
        end
        chk("rev_done", 16'(done_cnt - d0), 16'd1);
        chk("rev_idle", 16'(bus.fade_busy), 16'h0);

        // Start coincident with a vsync edge: that edge ignored.
        bus.vsync_in   = 1'b1;
        bus.fade_start = 1'b1;
        bus.fade_dir   = 1'b0;
        tick();
        bus.fade_start = 1'b0;
        bus.vsync_in   = 1'b0;
        tick();
        tick();
        vpulse();
        chk("coin_e1", 16'(bus.level), 16'd16);
        vpulse();
        chk("coin_e2", 16'(bus.level), 16'd15);

        // Level 15 on white: 225 -> E; then blanking forces black.
        bus.color_in = 12'hFFF;
        tick();
        tick();
        chk_rgb("rgb_l15", 12'hEEE);
        bus.de_in = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_rgb("rgb_blank", 12'h000);
        chk("de_low", 16'(bus.de_out), 16'h0);
        bus.de_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk_rgb("rgb_back", 12'hEEE);

        // Reset mid-fade: outputs clear at once, no done pulse.
        chk("mid_busy", 16'(bus.fade_busy), 16'h1);
        d0 = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        chk_rgb("mr_rgb", 12'h000);
        chk("mr_de", 16'(bus.de_out), 16'h0);
        chk("mr_lvl", 16'(bus.level), 16'd16);
        chk("mr_busy", 16'(bus.fade_busy), 16'h0);
        chk("mr_done", 16'(bus.fade_done), 16'h0);
        tick();
        tick();
        chk("mr_nodone", 16'(done_cnt - d0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
